// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the arbitration state encoding and the read-strobe constant.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } arb_state_t;

   localparam logic [3:0] STRB_READ = 4'b0000;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch vs. data) onto one shared memory port.
// Data wins by default; a fetch that has lost STARVE_MAX times in a row is forced through.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   input  logic [3:0]  dm_wstrb,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        if_stall
);

   localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] starve_cnt;
   logic             arb_open, fetch_force;
   logic             grant_if, grant_dm, if_done, dm_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // No arbitration while a ready pulse is out, so back-to-back transfers get one IDLE gap.
   always_comb begin
      state_d     = state_q;
      arb_open    = (state_q == IDLE) && !if_ready && !dm_ready;
      fetch_force = if_req && (starve_cnt == STARVE_LIM);
      case (state_q)
         IDLE: begin
            if (arb_open) begin
               if (if_req && (!dm_req || fetch_force)) state_d = IF_BUSY;
               else if (dm_req)                        state_d = DM_BUSY;
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (mem_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_if = (state_q == IDLE) && (state_d == IF_BUSY);
      grant_dm = (state_q == IDLE) && (state_d == DM_BUSY);
      if_done  = (state_q == IF_BUSY) && mem_ready;
      dm_done  = (state_q == DM_BUSY) && mem_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= STRB_READ;
         if_ready   <= 1'b0;
         dm_ready   <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
         starve_cnt <= '0;
      end else begin
         if_ready <= if_done;
         dm_ready <= dm_done;
         if (if_done) if_rdata <= mem_rdata;
         if (dm_done) dm_rdata <= mem_rdata;

         // Request fields are captured once at grant and held until the memory accepts.
         if (grant_if) begin
            mem_valid <= 1'b1;
            mem_addr  <= if_addr;
            mem_wstrb <= STRB_READ;
         end else if (grant_dm) begin
            mem_valid <= 1'b1;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_we ? dm_wstrb : STRB_READ;
         end else if (if_done || dm_done) begin
            mem_valid <= 1'b0;
         end

         if (grant_if)
            starve_cnt <= '0;
         else if (grant_dm && if_req && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   assign if_stall = if_req && !if_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, dm_req, dm_we, mem_ready;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic [3:0]  dm_wstrb;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        if_ready, dm_ready, mem_valid, if_stall;
   logic [3:0]  mem_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .if_stall(if_stall)
   );

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [3:0]  dm_wstrb;
      logic        mem_ready;
      logic [31:0] mem_rdata;
      logic        e_valid;
      logic [31:0] e_addr;
      logic [3:0]  e_wstrb;
      logic        e_ir;
      logic        e_dr;
      logic [31:0] e_ird;
      logic [31:0] e_drd;
      logic        e_stall;
   } vec_t;

   vec_t tbl [11];

   // Transaction-level reference: owner 0 = none, 1 = fetch, 2 = data.
   int          m_owner, m_starve;
   logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
   logic [3:0]  m_strb;
   logic        m_if_rdy, m_dm_rdy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
      dm_wdata = '0; dm_wstrb = '0; mem_ready = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic drain();
      if_req = 0; dm_req = 0; mem_ready = 1;
      repeat (3) tick();
      mem_ready = 0;
      tick();
   endtask

   function automatic void model_reset();
      m_owner = 0; m_starve = 0; m_addr = '0; m_wdata = '0; m_strb = '0;
      m_if_rd = '0; m_dm_rd = '0; m_if_rdy = 0; m_dm_rdy = 0;
   endfunction

   // Advance the model by one clock edge using the inputs present before that edge.
   function automatic void model_step();
      logic nif, ndm;
      nif = 0; ndm = 0;
      if (m_owner != 0) begin
         if (mem_ready) begin
            if (m_owner == 1) begin nif = 1; m_if_rd = mem_rdata; end
            else              begin ndm = 1; m_dm_rd = mem_rdata; end
            m_owner = 0;
         end
      end else if (!m_if_rdy && !m_dm_rdy) begin
         if (if_req && (!dm_req || m_starve == SMAX)) begin
            m_owner = 1; m_addr = if_addr; m_strb = 4'b0000; m_starve = 0;
         end else if (dm_req) begin
            m_owner = 2; m_addr = dm_addr; m_wdata = dm_wdata;
            m_strb = dm_we ? dm_wstrb : 4'b0000;
            if (if_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
         end
      end
      m_if_rdy = nif;
      m_dm_rdy = ndm;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int owners[$];
      int spins;

      tbl[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,          1, 32'h100, 0, 0, 0, 0, 0, 1};
      tbl[1]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0,          1, 32'h100, 0, 0, 0, 0, 0, 1};
      tbl[2]  = '{1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h13,     0, 0, 0, 1, 0, 32'h13, 0, 0};
      tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 32'h13, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD,         0, 0, 0, 0, 0, 32'h13, 0, 0};
      tbl[5]  = '{1, 32'h104, 1, 1, 32'h2000, 32'hAABBCCDD, 4'b0011, 0, 0,
                  1, 32'h2000, 4'b0011, 0, 0, 32'h13, 0, 1};
      tbl[6]  = '{1, 32'h104, 1, 1, 32'h2000, 32'hAABBCCDD, 4'b0011, 1, 32'h55,
                  0, 0, 0, 0, 1, 32'h13, 32'h55, 1};
      tbl[7]  = '{1, 32'h104, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 32'h13, 32'h55, 1};
      tbl[8]  = '{1, 32'h104, 0, 0, 0, 0, 0, 0, 0,          1, 32'h104, 0, 0, 0, 32'h13, 32'h55, 1};
      tbl[9]  = '{1, 32'h104, 0, 0, 0, 0, 0, 1, 32'h77,     0, 0, 0, 1, 0, 32'h77, 32'h55, 0};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 0, 0, 0, 32'h77, 32'h55, 0};

      // Reset state
      do_reset();
      chk("rst_mem_valid", 32'(mem_valid), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
      chk("rst_ready", {30'd0, if_ready, dm_ready}, 0);
      chk("rst_rdata", if_rdata | dm_rdata, 0);

      // Directed vectors: lone fetch, stray mem_ready, simultaneous requests
      for (int i = 0; i < 11; i++) begin
         if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
         dm_req = tbl[i].dm_req; dm_we = tbl[i].dm_we; dm_addr = tbl[i].dm_addr;
         dm_wdata = tbl[i].dm_wdata; dm_wstrb = tbl[i].dm_wstrb;
         mem_ready = tbl[i].mem_ready; mem_rdata = tbl[i].mem_rdata;
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(mem_valid), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d_addr", i), mem_addr, tbl[i].e_addr);
            chk($sformatf("vec%0d_wstrb", i), 32'(mem_wstrb), 32'(tbl[i].e_wstrb));
         end
         chk($sformatf("vec%0d_if_ready", i), 32'(if_ready), 32'(tbl[i].e_ir));
         chk($sformatf("vec%0d_dm_ready", i), 32'(dm_ready), 32'(tbl[i].e_dr));
         chk($sformatf("vec%0d_if_rdata", i), if_rdata, tbl[i].e_ird);
         chk($sformatf("vec%0d_dm_rdata", i), dm_rdata, tbl[i].e_drd);
         chk($sformatf("vec%0d_if_stall", i), 32'(if_stall), 32'(tbl[i].e_stall));
      end

      // Starvation: data wins STARVE_MAX grants, then fetch is forced
      if_req = 1; if_addr = 32'h200; dm_req = 1; dm_we = 0; dm_addr = 32'h5000;
      mem_ready = 1; mem_rdata = 32'h1;
      spins = 0;
      while (owners.size() < SMAX + 1 && spins < 40) begin
         tick();
         spins++;
         if (mem_valid) begin
            owners.push_back((mem_addr == 32'h5000) ? 2 : 1);
            if (owners.size() == SMAX + 1) chk("starve_cnt_clear", 32'(dut.starve_cnt), 0);
         end
      end
      chk("starve_grant_count", owners.size(), SMAX + 1);
      for (int i = 0; i < owners.size(); i++)
         chk($sformatf("starve_owner%0d", i), owners[i], (i < SMAX) ? 2 : 1);
      drain();

      // Memory wait states with a pending fetch stalled behind a load
      if_req = 1; if_addr = 32'h300; dm_req = 1; dm_we = 0; dm_addr = 32'h3000;
      dm_wstrb = 4'b1111; mem_ready = 0;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("wait_valid", 32'(mem_valid), 1);
         chk("wait_addr", mem_addr, 32'h3000);
         chk("wait_wstrb", 32'(mem_wstrb), 0);
         chk("wait_dm_ready", 32'(dm_ready), 0);
         chk("wait_if_stall", 32'(if_stall), 1);
         tick();
      end
      mem_ready = 1; mem_rdata = 32'h99;
      tick();
      chk("wait_done_ready", 32'(dm_ready), 1);
      chk("wait_done_rdata", dm_rdata, 32'h99);
      chk("wait_done_valid", 32'(mem_valid), 0);
      dm_req = 0; mem_ready = 0;
      tick();
      chk("wait_single_pulse", 32'(dm_ready), 0);
      drain();

      // Asynchronous reset while a data transfer is outstanding
      dm_req = 1; dm_we = 1; dm_addr = 32'h4000; dm_wdata = 32'h1234; dm_wstrb = 4'b0001;
      tick();
      chk("rstmid_granted", 32'(mem_valid), 1);
      rst_n = 0;
      #1;
      chk("rstmid_valid_async", 32'(mem_valid), 0);
      tick();
      chk("rstmid_no_ready", 32'(dm_ready), 0);
      rst_n = 1;
      tick();
      chk("rstmid_regrant", 32'(mem_valid), 1);
      chk("rstmid_regrant_addr", mem_addr, 32'h4000);
      chk("rstmid_regrant_wstrb", 32'(mem_wstrb), 32'h1);
      chk("rstmid_no_ready2", 32'(dm_ready), 0);
      drain();

      // Randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int c = 0; c < 500; c++) begin
         if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
         dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
         dm_addr = $urandom; dm_wdata = $urandom; dm_wstrb = 4'($urandom);
         mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
         model_step();
         tick();
         chk("rnd_valid", 32'(mem_valid), 32'(m_owner != 0));
         if (m_owner != 0) begin
            chk("rnd_addr", mem_addr, m_addr);
            chk("rnd_wstrb", 32'(mem_wstrb), 32'(m_strb));
            if (m_owner == 2) chk("rnd_wdata", mem_wdata, m_wdata);
         end
         chk("rnd_if_ready", 32'(if_ready), 32'(m_if_rdy));
         chk("rnd_dm_ready", 32'(dm_ready), 32'(m_dm_rdy));
         chk("rnd_if_rdata", if_rdata, m_if_rd);
         chk("rnd_dm_rdata", dm_rdata, m_dm_rd);
         chk("rnd_if_stall", 32'(if_stall), 32'(if_req && !m_if_rdy));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
